ifetch_cached_bp: RTL
=====================

IFETCH_CACHED_BP -- requirements
Module: ifetch_cached_bp

Interface
REQ-001 Parameter ICACHE_SETS, default 16, number of direct-mapped cache sets (power of 2, >=2).
REQ-002 Parameter BLOCK_WORDS, default 16, 32-bit instructions per cache block (power of 2, >=2).
REQ-003 Parameter BHT_ENTRIES, default 256, number of 2-bit branch counters (power of 2).
REQ-004 Parameter BP_MODE, default 1, 0 = static not-taken for branches, 1 = bimodal BHT.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 rdy  in  1  global enable; when 0, no register changes state.
REQ-009 stall  in  1  backend full (RS/LSB/ROB next-full, pre-ORed).
REQ-010 inst  out  32  fetched instruction.
REQ-011 inst_vld  out  1  inst/inst_pc/inst_pred_jump valid this cycle.
REQ-012 inst_pc  out  32  address of inst.
REQ-013 inst_pred_jump  out  1  predicted taken.
REQ-014 mc_req  out  1  block-fill request to memory controller.
REQ-015 mc_addr  out  32  block-aligned fill address.
REQ-016 mc_data  in  32*BLOCK_WORDS  fill data, word 0 in bits [31:0].
REQ-017 mc_done  in  1  one-cycle pulse, mc_data valid.
REQ-018 redirect_en, redirect_pc  in  1, 32  ROB mispredict/flush, new fetch pc.
REQ-019 br_commit, br_taken, br_pc  in  1, 1, 32  committed conditional branch outcome.

Function
REQ-020 Address split: offset = pc[1+log2(BLOCK_WORDS):2], index = next log2(ICACHE_SETS) bits, tag = remaining upper bits.
REQ-021 Hit = valid[index] and tag match; output registers update one cycle after hit (1-cycle latency).
REQ-022 Per enabled cycle, priority: redirect_en (pc <= redirect_pc, inst_vld <= 0) > miss (inst_vld <= 0) > stall (inst_vld <= 0, pc held) > hit (emit, pc <= pred_pc).
REQ-023 Fill FSM states IDLE, WAIT_MEM; IDLE with miss -> mc_req <= 1, mc_addr <= pc with offset and bits[1:0] zeroed, -> WAIT_MEM.
REQ-024 WAIT_MEM: mc_req and mc_addr held stable until mc_done; on mc_done write valid/tag/data of mc_addr's set, mc_req <= 0, -> IDLE.
REQ-025 redirect_en during WAIT_MEM SHALL NOT abort the fill; the block is installed, then the new pc is looked up and a fresh request issued if it misses.
REQ-026 Minimum one IDLE cycle between consecutive fills (mc_req low for >=1 cycle).
REQ-027 Prediction: opcode 1101111 (JAL) -> pred_pc = pc + sext J-imm, pred_jump = 1.
REQ-028 Opcode 1100011 (branch) with BP_MODE=1 and counter >= 2 -> pred_pc = pc + sext B-imm, pred_jump = 1; otherwise pc+4, pred_jump = 0.
REQ-029 All other opcodes, including JALR: pred_pc = pc+4, pred_jump = 0; 32-bit wrap-around permitted.
REQ-030 BHT index = pc[1+log2(BHT_ENTRIES):2]; br_commit with br_taken increments, else decrements, saturating at 3 and 0.
REQ-031 BHT update and lookup of same entry in one cycle: lookup uses pre-update value.
REQ-032 With BP_MODE=0 the BHT SHALL not be instantiated.

Reset
REQ-033 rst_n low: pc=0, inst_vld=0, inst_pred_jump=0, mc_req=0, mc_addr=0, FSM=IDLE, all valid bits 0, all BHT counters 0; inst, inst_pc, tag, data arrays need not reset.
REQ-034 Reset during WAIT_MEM drops mc_req immediately; a later mc_done without an outstanding request SHALL be ignored.

Structure
REQ-035 Shared package holds opcode constants (JAL, BRANCH), instruction width 32, and default parameter values.
REQ-036 BHT SHALL be a sub-module fetch_bht (BHT_ENTRIES parameter; lookup index in, counter out; update port).

Verification
REQ-037 Cold start pc=0, mc_done 3 cycles after mc_req with block of ADDI -> mc_addr=0x0, then inst_vld per cycle with inst_pc 0x0,0x4,0x8...
REQ-038 JAL at 0x10 with imm +0x40 -> inst_pred_jump=1, next inst_pc=0x50.
REQ-039 Branch at 0x20, three br_commit taken -> next fetch of 0x20 predicts taken; BP_MODE=0 -> never taken.
REQ-040 redirect_en to 0x400 while fill of 0x0 pending -> block 0x0 installed, then mc_req with mc_addr=0x400, no inst_vld until 0x400 hit.
REQ-041 stall held 5 cycles at pc 0x8 on hit -> inst_vld=0, pc unchanged, resumes with inst_pc=0x8.
REQ-042 rst_n asserted mid-WAIT_MEM -> mc_req=0 same cycle, valid bits cleared, stray mc_done ignored.

Source files
------------

// File: rtl/ifetch_cached_bp_pkg.sv
// Shared constants and helpers for the cached instruction fetch unit.
package ifetch_cached_bp_pkg;

  localparam int unsigned ILEN            = 32;
  localparam int unsigned DEF_ICACHE_SETS = 16;
  localparam int unsigned DEF_BLOCK_WORDS = 16;
  localparam int unsigned DEF_BHT_ENTRIES = 256;
  localparam int unsigned DEF_BP_MODE     = 1;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    FILL_IDLE,
    FILL_WAIT_MEM
  } fill_state_e;

  // Sign-extended J-type immediate (JAL target offset).
  function automatic logic [ILEN-1:0] imm_j(input logic [ILEN-1:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // Sign-extended B-type immediate (conditional branch offset).
  function automatic logic [ILEN-1:0] imm_b(input logic [ILEN-1:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_bht.sv
// Bimodal branch history table: 2-bit saturating counters, async read.
module fetch_bht
  import ifetch_cached_bp_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = DEF_BHT_ENTRIES,
  localparam int unsigned IW = $clog2(BHT_ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [IW-1:0] lookup_idx_i,
  output logic [1:0]    lookup_ctr_o,
  input  logic          upd_en_i,
  input  logic [IW-1:0] upd_idx_i,
  input  logic          upd_taken_i
);

  logic [1:0] ctr_q [BHT_ENTRIES];
  logic [1:0] upd_ctr_d;

  // Lookup sees the stored value, so a same-cycle update is not forwarded.
  assign lookup_ctr_o = ctr_q[lookup_idx_i];

  // Saturating increment/decrement of the entry being trained.
  always_comb begin
    upd_ctr_d = ctr_q[upd_idx_i];
    if (upd_taken_i) begin
      if (ctr_q[upd_idx_i] != 2'd3) upd_ctr_d = ctr_q[upd_idx_i] + 2'd1;
    end else begin
      if (ctr_q[upd_idx_i] != 2'd0) upd_ctr_d = ctr_q[upd_idx_i] - 2'd1;
    end
  end

  // Counter storage, cleared to strongly-not-taken on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctr_q <= '{default: '0};
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= upd_ctr_d;
    end
  end

endmodule

// File: rtl/ifetch_cached_bp.sv
// Instruction fetch with direct-mapped I-cache, block fill FSM and
// JAL / bimodal branch prediction.
module ifetch_cached_bp
  import ifetch_cached_bp_pkg::*;
#(
  parameter int unsigned ICACHE_SETS = DEF_ICACHE_SETS,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned BHT_ENTRIES = DEF_BHT_ENTRIES,
  parameter int unsigned BP_MODE     = DEF_BP_MODE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rdy,
  input  logic                        stall,
  output logic [ILEN-1:0]             inst,
  output logic                        inst_vld,
  output logic [31:0]                 inst_pc,
  output logic                        inst_pred_jump,
  output logic                        mc_req,
  output logic [31:0]                 mc_addr,
  input  logic [ILEN*BLOCK_WORDS-1:0] mc_data,
  input  logic                        mc_done,
  input  logic                        redirect_en,
  input  logic [31:0]                 redirect_pc,
  input  logic                        br_commit,
  input  logic                        br_taken,
  input  logic [31:0]                 br_pc
);

  localparam int unsigned OFF_W   = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W   = $clog2(ICACHE_SETS);
  localparam int unsigned TAG_LSB = OFF_W + IDX_W + 2;
  localparam int unsigned TAG_W   = 32 - TAG_LSB;
  localparam int unsigned BHT_W   = $clog2(BHT_ENTRIES);

  logic [31:0]       pc_q, pc_d;
  logic              inst_vld_q, inst_vld_d;
  logic [ILEN-1:0]   inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              pred_jump_q, pred_jump_d;
  logic              mc_req_q, mc_req_d;
  logic [31:0]       mc_addr_q, mc_addr_d;
  fill_state_e       state_q, state_d;
  logic              fill_we;

  logic [ICACHE_SETS-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [ICACHE_SETS];
  logic [ILEN-1:0]        data_q [ICACHE_SETS][BLOCK_WORDS];

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic             hit;
  logic [ILEN-1:0]  fetch_word;
  logic [1:0]       bht_ctr;
  logic [31:0]      pred_pc;
  logic             pred_jump;

  assign pc_off     = pc_q[OFF_W+1:2];
  assign pc_idx     = pc_q[TAG_LSB-1:OFF_W+2];
  assign pc_tag     = pc_q[31:TAG_LSB];
  assign fill_idx   = mc_addr_q[TAG_LSB-1:OFF_W+2];
  assign fill_tag   = mc_addr_q[31:TAG_LSB];
  assign hit        = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign fetch_word = data_q[pc_idx][pc_off];

  generate
    if (BP_MODE == 1) begin : g_bht
      fetch_bht #(
        .BHT_ENTRIES(BHT_ENTRIES)
      ) u_bht (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .lookup_idx_i(pc_q[BHT_W+1:2]),
        .lookup_ctr_o(bht_ctr),
        .upd_en_i    (rdy & br_commit),
        .upd_idx_i   (br_pc[BHT_W+1:2]),
        .upd_taken_i (br_taken)
      );
    end else begin : g_no_bht
      assign bht_ctr = 2'b00;
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{br_pc, br_taken, br_commit, pc_q[1:0], mc_addr_q[OFF_W+1:0]};

  // Next-pc prediction from the word currently being looked up.
  always_comb begin
    pred_pc   = pc_q + 32'd4;
    pred_jump = 1'b0;
    if (fetch_word[6:0] == OPC_JAL) begin
      pred_pc   = pc_q + imm_j(fetch_word);
      pred_jump = 1'b1;
    end else if ((fetch_word[6:0] == OPC_BRANCH) && (BP_MODE == 1) && bht_ctr[1]) begin
      pred_pc   = pc_q + imm_b(fetch_word);
      pred_jump = 1'b1;
    end
  end

  // Fetch pipeline: redirect > miss > stall > emit.
  always_comb begin
    pc_d        = pc_q;
    inst_vld_d  = 1'b0;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    pred_jump_d = pred_jump_q;
    if (redirect_en) begin
      pc_d = redirect_pc;
    end else if (hit && !stall) begin
      inst_vld_d  = 1'b1;
      inst_d      = fetch_word;
      inst_pc_d   = pc_q;
      pred_jump_d = pred_jump;
      pc_d        = pred_pc;
    end
  end

  // Fill FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Fill FSM next state; a redirect never cancels an outstanding fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL_IDLE:     if (!hit)   state_d = FILL_WAIT_MEM;
      FILL_WAIT_MEM: if (mc_done) state_d = FILL_IDLE;
      default:       state_d = FILL_IDLE;
    endcase
  end

  // Fill FSM outputs; mc_done outside WAIT_MEM is ignored.
  always_comb begin
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;
    fill_we   = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (!hit) begin
          mc_req_d  = 1'b1;
          mc_addr_d = {pc_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        end
      end
      FILL_WAIT_MEM: begin
        if (mc_done) begin
          mc_req_d = 1'b0;
          fill_we  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control and output registers, all frozen while rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      inst_vld_q  <= 1'b0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      pred_jump_q <= 1'b0;
      mc_req_q    <= 1'b0;
      mc_addr_q   <= '0;
      valid_q     <= '0;
    end else if (rdy) begin
      pc_q        <= pc_d;
      inst_vld_q  <= inst_vld_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      pred_jump_q <= pred_jump_d;
      mc_req_q    <= mc_req_d;
      mc_addr_q   <= mc_addr_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays, written only on a completed fill.
  always_ff @(posedge clk) begin
    if (rdy && fill_we) begin
      tag_q[fill_idx] <= fill_tag;
      for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
        data_q[fill_idx][w[OFF_W-1:0]] <= mc_data[w*ILEN +: ILEN];
      end
    end
  end

  assign inst           = inst_q;
  assign inst_vld       = inst_vld_q;
  assign inst_pc        = inst_pc_q;
  assign inst_pred_jump = pred_jump_q;
  assign mc_req         = mc_req_q;
  assign mc_addr        = mc_addr_q;

endmodule
